rally_controller: RTL and testbench

RALLY_CONTROLLER -- requirements
Module: rally_controller

---
 rtl/rally_pkg.sv | 35 +++
 rtl/rally_controller_rise_detect.sv | 20 ++
 rtl/rally_controller.sv | 185 ++++++++++++++++++
 tb/tb_rally_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rally_pkg.sv
// Shared definitions for the rally (pong-style) game controller: state
// encoding, serve/direction codes and the hit/end masks on the light bar.
package rally_pkg;

  // Controller state encoding, also exposed on the state output.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_RALLY     = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } rally_state_e;

  // Serve command codes to the ball datapath.
  localparam logic [1:0] SERVE_NONE  = 2'b00;
  localparam logic [1:0] SERVE_LEFT  = 2'b01;
  localparam logic [1:0] SERVE_RIGHT = 2'b10;

  // Ball direction codes from the ball datapath.
  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // Light bar masks: bit 15 is the left end, bit 0 the right end.
  localparam logic [15:0] LEFT_ZONE  = 16'hC000;
  localparam logic [15:0] RIGHT_ZONE = 16'h0003;
  localparam logic [15:0] LEFT_END   = 16'h8000;
  localparam logic [15:0] RIGHT_END  = 16'h0001;

  // Score increment that sticks at the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v == lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rally_controller_rise_detect.sv
// One-register rising-edge detector: o_pulse is high for the single cycle
// in which i_level is high and was low at the previous clock edge.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // Remember last cycle's level; reset forgets it.
  always_ff @(posedge clock) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/rally_controller.sv
// Game controller for a two-player light-bar rally. Accepts player hits in
// the end zones, detects misses when the ball dwells on an end light, keeps
// score and sequences serve / rally / point pause / game over.
//
// Handshake note: there is no valid/ready flow here. serve is a one-cycle
// command valid only in SERVE; leftdirection/rightdirection are one-cycle
// pulses issued the cycle after an accepted press; the ball datapath is
// expected to act on each pulse without back-pressure.
module rally_controller
  import rally_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int EDGE_HOLD   = 4,
  parameter int POINT_PAUSE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [15:0] light,
  input  logic [1:0]  direction,
  input  logic [2:0]  hitnum,
  output logic [1:0]  serve,
  output logic        leftdirection,
  output logic        rightdirection,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        server,
  output logic [1:0]  winner,
  output logic [2:0]  best_rally,
  output logic [2:0]  state
);

  localparam logic [3:0] WIN_C        = 4'(WIN_SCORE);
  localparam logic [7:0] EDGE_HOLD_C  = 8'(EDGE_HOLD);
  localparam logic [7:0] PAUSE_LAST_C = 8'(POINT_PAUSE - 1);

  rally_state_e r_state;
  logic [7:0]   r_edge_cnt;
  logic [7:0]   r_pause_cnt;
  logic [3:0]   r_score_l;
  logic [3:0]   r_score_r;
  logic         r_server;
  logic [1:0]   r_winner;
  logic [2:0]   r_best;
  logic         r_leftdir;
  logic         r_rightdir;

  logic       w_press_l;
  logic       w_press_r;
  logic       w_in_rally;
  logic       w_hit_l;
  logic       w_hit_r;
  logic       w_at_left_end;
  logic       w_at_right_end;
  logic       w_at_end;
  logic [7:0] w_edge_next;
  logic       w_miss;

  rise_detect u_rise_left (
    .clock   (clock),
    .reset   (reset),
    .i_level (btn_left),
    .o_pulse (w_press_l)
  );

  rise_detect u_rise_right (
    .clock   (clock),
    .reset   (reset),
    .i_level (btn_right),
    .o_pulse (w_press_r)
  );

  assign w_in_rally = (r_state == ST_RALLY);

  // A press counts only in its own zone while the ball travels toward that player.
  assign w_hit_l = w_in_rally && w_press_l && ((light & LEFT_ZONE) != '0)
                   && (direction == DIR_LEFT);
  assign w_hit_r = w_in_rally && w_press_r && ((light & RIGHT_ZONE) != '0)
                   && (direction == DIR_RIGHT);

  // Ball sitting on an end light while still heading outward.
  assign w_at_left_end  = ((light & LEFT_END) != '0)  && (direction == DIR_LEFT);
  assign w_at_right_end = ((light & RIGHT_END) != '0) && (direction == DIR_RIGHT);
  assign w_at_end       = w_at_left_end || w_at_right_end;

  assign w_edge_next = r_edge_cnt + 8'd1;
  // An accepted hit on the end light rescues the ball in that same cycle.
  assign w_miss = w_in_rally && w_at_end && !w_hit_l && !w_hit_r
                  && (w_edge_next == EDGE_HOLD_C);

  // Register accepted hits into one-cycle pulses to the ball datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_leftdir  <= 1'b0;
      r_rightdir <= 1'b0;
    end else begin
      r_leftdir  <= w_hit_l;
      r_rightdir <= w_hit_r;
    end
  end

  // Count consecutive end-light dwell cycles during a rally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_edge_cnt <= '0;
    end else if (w_in_rally && w_at_end && !w_hit_l && !w_hit_r && !w_miss) begin
      r_edge_cnt <= w_edge_next;
    end else begin
      r_edge_cnt <= '0;
    end
  end

  // Game sequencing, scoring and point pause.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pause_cnt <= '0;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_server    <= 1'b0;
      r_winner    <= 2'b00;
      r_best      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            r_score_l <= '0;
            r_score_r <= '0;
            r_winner  <= 2'b00;
            r_server  <= 1'b0;
            r_state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          r_state <= ST_RALLY;
        end
        ST_RALLY: begin
          if (w_miss) begin
            if (w_at_right_end) begin
              r_score_l <= sat_inc(r_score_l, WIN_C);
              r_server  <= 1'b0;
            end else begin
              r_score_r <= sat_inc(r_score_r, WIN_C);
              r_server  <= 1'b1;
            end
            if (hitnum > r_best) r_best <= hitnum;
            r_pause_cnt <= '0;
            r_state     <= ST_POINT;
          end
        end
        ST_POINT: begin
          if (r_pause_cnt == PAUSE_LAST_C) begin
            r_pause_cnt <= '0;
            if (r_score_l == WIN_C) begin
              r_winner <= 2'b01;
              r_state  <= ST_GAME_OVER;
            end else if (r_score_r == WIN_C) begin
              r_winner <= 2'b10;
              r_state  <= ST_GAME_OVER;
            end else begin
              r_state <= ST_SERVE;
            end
          end else begin
            r_pause_cnt <= r_pause_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign serve          = (r_state == ST_SERVE) ? (r_server ? SERVE_RIGHT : SERVE_LEFT)
                                                : SERVE_NONE;
  assign leftdirection  = r_leftdir;
  assign rightdirection = r_rightdir;
  assign score_left     = r_score_l;
  assign score_right    = r_score_r;
  assign server         = r_server;
  assign winner         = r_winner;
  assign best_rally     = r_best;
  assign state          = r_state;

endmodule

// File: tb/tb_rally_controller.sv
// Bench for rally_controller: directed game scenarios plus randomized play,
// all outputs checked every cycle against a game-rules model.
module tb_rally_controller;
  import rally_pkg::*;

  localparam int WIN   = 5;
  localparam int HOLD  = 4;
  localparam int PAUSE = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic [15:0] light = 16'h0100;
  logic [1:0]  direction = 2'b00;
  logic [2:0]  hitnum = 3'd0;

  logic [1:0] serve;
  logic       leftdirection, rightdirection;
  logic [3:0] score_left, score_right;
  logic       server;
  logic [1:0] winner;
  logic [2:0] best_rally;
  logic [2:0] state;

  rally_controller #(.WIN_SCORE(WIN), .EDGE_HOLD(HOLD), .POINT_PAUSE(PAUSE)) dut (
    .clock(clock), .reset(reset), .start(start),
    .btn_left(btn_left), .btn_right(btn_right),
    .light(light), .direction(direction), .hitnum(hitnum),
    .serve(serve), .leftdirection(leftdirection), .rightdirection(rightdirection),
    .score_left(score_left), .score_right(score_right), .server(server),
    .winner(winner), .best_rally(best_rally), .state(state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game-rules model ----------------
  localparam int P_IDLE = 0, P_SERVE = 1, P_RALLY = 2, P_POINT = 3, P_OVER = 4;
  int m_phase = P_IDLE;
  int m_sl = 0, m_sr = 0, m_server = 0, m_win = 0, m_best = 0;
  int m_dwell = 0, m_pause_left = 0;
  bit m_ld = 0, m_rd = 0, m_prev_l = 0, m_prev_r = 0, m_valid = 0;

  function automatic logic [2:0] phase_code(input int p);
    case (p)
      P_IDLE:  return ST_IDLE;
      P_SERVE: return ST_SERVE;
      P_RALLY: return ST_RALLY;
      P_POINT: return ST_POINT;
      default: return ST_GAME_OVER;
    endcase
  endfunction

  always @(posedge clock) begin
    bit pl, pr, hl, hr, lend, rend;
    pl = btn_left && !m_prev_l;
    pr = btn_right && !m_prev_r;
    m_prev_l = btn_left;
    m_prev_r = btn_right;
    if (reset) begin
      m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_server = 0; m_win = 0; m_best = 0;
      m_dwell = 0; m_pause_left = 0; m_ld = 0; m_rd = 0;
      m_prev_l = 0; m_prev_r = 0; m_valid = 1;
    end else begin
      hl = (m_phase == P_RALLY) && pl && (light[15] || light[14]) && (direction == 2'b01);
      hr = (m_phase == P_RALLY) && pr && (light[1] || light[0]) && (direction == 2'b10);
      lend = light[15] && (direction == 2'b01);
      rend = light[0] && (direction == 2'b10);
      m_ld = hl;
      m_rd = hr;
      case (m_phase)
        P_IDLE, P_OVER: if (start) begin
          m_sl = 0; m_sr = 0; m_win = 0; m_server = 0; m_phase = P_SERVE;
        end
        P_SERVE: m_phase = P_RALLY;
        P_RALLY: begin
          if (hl || hr) m_dwell = 0;
          else if (lend || rend) begin
            m_dwell++;
            if (m_dwell == HOLD) begin
              m_dwell = 0;
              if (rend) begin m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_server = 0; end
              else      begin m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_server = 1; end
              if (int'(hitnum) > m_best) m_best = int'(hitnum);
              m_pause_left = PAUSE;
              m_phase = P_POINT;
            end
          end else m_dwell = 0;
        end
        P_POINT: begin
          m_pause_left--;
          if (m_pause_left == 0) begin
            if (m_sl == WIN)      begin m_win = 1; m_phase = P_OVER; end
            else if (m_sr == WIN) begin m_win = 2; m_phase = P_OVER; end
            else m_phase = P_SERVE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (m_phase != P_RALLY) m_dwell = 0;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("state",       16'(state),          16'(phase_code(m_phase)));
      chk("serve",       16'(serve),          (m_phase == P_SERVE) ? (m_server ? 16'd2 : 16'd1) : 16'd0);
      chk("leftdir",     16'(leftdirection),  16'(m_ld));
      chk("rightdir",    16'(rightdirection), 16'(m_rd));
      chk("score_left",  16'(score_left),     16'(m_sl));
      chk("score_right", 16'(score_right),    16'(m_sr));
      chk("server",      16'(server),         16'(m_server));
      chk("winner",      16'(winner),         16'(m_win));
      chk("best_rally",  16'(best_rally),     16'(m_best));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic ball(input logic [15:0] l, input logic [1:0] d);
    light = l;
    direction = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 16'(state), 16'(ST_IDLE));
    chk({tag, "_outs"}, {serve, leftdirection, rightdirection, server, winner, best_rally},
        16'h0000);
    chk({tag, "_scores"}, {score_left, score_right}, 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] lv;
    int pos, r;

    // reset and first serve
    cycles(2);
    reset = 1'b0;
    chk_all_zero("reset");
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("first_serve", 16'(serve), 16'h0001);
    cycle();
    chk("rally_after_serve", 16'(state), 16'(ST_RALLY));
    chk("serve_one_cycle", 16'(serve), 16'h0000);

    // accepted left hit: one pulse, no repeat while held
    ball(16'h4000, 2'b01);
    btn_left = 1'b1;
    cycle();
    chk("left_hit_pulse", 16'(leftdirection), 16'h0001);
    cycle();
    chk("left_hit_no_repeat", 16'(leftdirection), 16'h0000);
    btn_left = 1'b0;
    cycle();

    // presses outside zone / wrong direction are ignored
    ball(16'h0100, 2'b01);
    btn_left = 1'b1;
    cycle();
    chk("left_wrong_zone", 16'(leftdirection), 16'h0000);
    btn_left = 1'b0;
    ball(16'h0001, 2'b01);
    btn_right = 1'b1;
    cycle();
    chk("right_wrong_dir", 16'(rightdirection), 16'h0000);
    btn_right = 1'b0;

    // left-end miss -> point to right
    hitnum = 3'd3;
    ball(16'h8000, 2'b01);
    cycles(HOLD);
    chk("miss_state", 16'(state), 16'(ST_POINT));
    chk("miss_score_right", 16'(score_right), 16'h0001);
    chk("miss_server", 16'(server), 16'h0001);
    chk("miss_best", 16'(best_rally), 16'h0003);
    ball(16'h0100, 2'b00);
    cycles(PAUSE);
    chk("right_serves", 16'(serve), 16'h0002);

    // right wins a whole game
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    for (int i = 0; i < WIN; i++) begin
      ball(16'h8000, 2'b01);
      cycles(HOLD);
      ball(16'h0100, 2'b00);
      cycles(PAUSE);
      if (i < WIN - 1) cycle();
    end
    chk("go_state", 16'(state), 16'(ST_GAME_OVER));
    chk("go_winner", 16'(winner), 16'h0002);
    chk("go_scores", {score_left, score_right}, 16'h0005);
    start = 1'b0;
    cycles(5);
    chk("go_held", {score_left, score_right, 6'd0, winner}, 16'h0502);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_serve", 16'(serve), 16'h0001);
    chk("restart_scores", {score_left, score_right, 6'd0, winner}, 16'h0000);

    // two left points, then reset mid-rally
    cycle();
    for (int i = 0; i < 2; i++) begin
      ball(16'h0001, 2'b10);
      cycles(HOLD);
      ball(16'h0100, 2'b00);
      cycles(PAUSE);
      cycle();
    end
    chk("mid_rally_score", 16'(score_left), 16'h0002);
    ball(16'h4000, 2'b01);
    btn_left = 1'b1;
    reset = 1'b1;
    cycle();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    btn_left = 1'b0;

    // randomized play
    pos = 8;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 3) pos = 15;
        else if (r < 6) pos = 0;
        else if (r == 6) pos = 14;
        else if (r == 7) pos = 1;
        else pos = $urandom_range(0, 15);
      end
      lv = 16'h0001;
      light = lv << pos;
      if ($urandom_range(0, 7) == 0) direction = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 2) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 15) == 0) hitnum = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 799) == 0);
      cycle();
    end
    reset = 1'b0;
    start = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
